// File: rtl/video_pkg.sv
// Shared timing defaults, pattern-mode encoding and pixel type for the
// 640x480 test-pattern source.
package video_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    // Counter width; covers totals up to 4095 in either direction.
    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pat_mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Colour-bar index 0..7 for column h, bars of width bar_w.
    // Threshold compares instead of a divider.
    function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] h,
                                             input logic [CNT_W-1:0] bar_w);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h >= CNT_W'(i) * bar_w) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters and combinational de/hsync/vsync/frame-boundary decode.
// The first enabled cycle only arms the generator, so (0,0) is decoded
// one cycle after en rises.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_h,
    output logic             o_v_tile,
    output logic             o_de,
    output logic             o_hsync_n,
    output logic             o_vsync_n,
    output logic             o_frame_first,
    output logic             o_frame_last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] L_H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] L_H_HS0  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] L_H_HS1  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] L_H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] L_V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] L_V_VS0  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] L_V_VS1  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] L_V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_run;
    logic             w_active;
    logic             w_h_wrap;

    assign w_active = r_run & i_en;
    assign w_h_wrap = (r_h == L_H_LAST);

    // Raster position: parked at (0,0) while disabled, advances once armed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h   <= '0;
            r_v   <= '0;
            r_run <= 1'b0;
        end else if (!i_en) begin
            r_h   <= '0;
            r_v   <= '0;
            r_run <= 1'b0;
        end else if (!r_run) begin
            r_run <= 1'b1;
        end else if (w_h_wrap) begin
            r_h <= '0;
            r_v <= (r_v == L_V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign o_h           = r_h;
    assign o_v_tile      = r_v[5];
    assign o_de          = w_active && (r_h < L_H_ACT) && (r_v < L_V_ACT);
    assign o_hsync_n     = !(w_active && (r_h >= L_H_HS0) && (r_h < L_H_HS1));
    assign o_vsync_n     = !(w_active && (r_v >= L_V_VS0) && (r_v < L_V_VS1));
    assign o_frame_first = w_active && (r_h == '0) && (r_v == '0);
    assign o_frame_last  = w_active && w_h_wrap && (r_v == L_V_LAST);

endmodule

// File: rtl/video_pattern_tx.sv
// Test-pattern video source: timing generator, per-frame mode latch,
// pattern mux and a single output register stage so RGB, DE and syncs
// leave the block mutually aligned.
module video_pattern_tx
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam logic [CNT_W-1:0] L_BAR_W = CNT_W'(H_ACTIVE / 8);

    logic [CNT_W-1:0] w_h;
    logic             w_v_tile;
    logic             w_de;
    logic             w_hsync_n;
    logic             w_vsync_n;
    logic             w_first;
    logic             w_last;
    pat_mode_e        w_mode;
    rgb888_t          w_solid;
    rgb888_t          w_pix;
    logic [2:0]       w_bar;

    pat_mode_e        r_mode;
    rgb888_t          r_rgb;
    rgb888_t          r_pix;
    logic             r_de;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;
    logic [15:0]      r_frame_cnt;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .o_h           (w_h),
        .o_v_tile      (w_v_tile),
        .o_de          (w_de),
        .o_hsync_n     (w_hsync_n),
        .o_vsync_n     (w_vsync_n),
        .o_frame_first (w_first),
        .o_frame_last  (w_last)
    );

    // Pixel (0,0) already uses the values being latched on that cycle.
    assign w_mode  = w_first ? pat_mode_e'(mode) : r_mode;
    assign w_solid = w_first ? rgb888_t'(solid_rgb) : r_rgb;
    assign w_bar   = bar_index(w_h, L_BAR_W);

    // Pattern selection; blanking forces black.
    always_comb begin
        w_pix = '0;
        if (w_de) begin
            case (w_mode)
                PAT_BARS:  w_pix = '{r: {8{w_bar[2]}}, g: {8{w_bar[1]}}, b: {8{w_bar[0]}}};
                PAT_RAMP:  w_pix = '{r: w_h[9:2], g: w_h[9:2], b: w_h[9:2]};
                PAT_CHECK: w_pix = {24{w_h[5] ^ w_v_tile}};
                default:   w_pix = w_solid;
            endcase
        end
    end

    // Capture mode and colour at the top of each frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= PAT_BARS;
            r_rgb  <= '0;
        end else if (w_first) begin
            r_mode <= pat_mode_e'(mode);
            r_rgb  <= rgb888_t'(solid_rgb);
        end
    end

    // Output register stage and completed-frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix         <= '0;
            r_de          <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_pix         <= w_pix;
            r_de          <= w_de;
            r_hsync       <= w_hsync_n;
            r_vsync       <= w_vsync_n;
            r_frame_start <= w_first;
            if (w_last) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign red         = r_pix.r;
    assign green       = r_pix.g;
    assign blue        = r_pix.b;
    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_pattern_tx.sv
// Bench for video_pattern_tx with a shortened vertical raster so several
// frames fit in a short run. A pixel-index model predicts every output.
module tb_video_pattern_tx;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 33,  VF = 1,  VS = 2,  VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int F  = HT * VT;

    logic        clk, rst, en;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic [7:0]  red, green, blue;
    logic        de, hsync, vsync, frame_start;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int k;
    bit rnd_rgb  = 0;
    bit rnd_mode = 0;

    video_pattern_tx #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pattern for column h, line v.
    function automatic logic [23:0] pat(input int m, input logic [23:0] s,
                                        input int h, input int v);
        logic [2:0] bb;
        logic [7:0] r;
        if (h >= HA || v >= VA) return 24'h0;
        case (m)
            0: begin
                bb = 3'(h / (HA / 8));
                return {{8{bb[2]}}, {8{bb[1]}}, {8{bb[0]}}};
            end
            1: begin
                r = 8'(h / 4);
                return {r, r, r};
            end
            2: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h0;
            default: return s;
        endcase
    endfunction

    // Model: pixel index since the stream started, mapped to (h,v).
    bit          m_started;
    int          m_p;
    int          m_lmode;
    logic [23:0] m_lrgb;
    logic [15:0] m_fcnt;
    logic [43:0] m_exp;

    always @(posedge clk or posedge rst) begin
        int h, v;
        if (rst) begin
            m_started = 0;
            m_p       = 0;
            m_lmode   = 0;
            m_lrgb    = 24'h0;
            m_fcnt    = 16'h0;
            m_exp     = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
        end else if (!en) begin
            m_started = 0;
            m_exp     = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, m_fcnt};
        end else if (!m_started) begin
            m_started = 1;
            m_p       = 0;
            m_exp     = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, m_fcnt};
        end else begin
            h = m_p % HT;
            v = m_p / HT;
            if (m_p == 0) begin
                m_lmode = int'(mode);
                m_lrgb  = solid_rgb;
            end
            if (m_p == F - 1) begin
                m_fcnt = m_fcnt + 16'd1;
                m_p    = 0;
            end else begin
                m_p = m_p + 1;
            end
            m_exp = {pat(m_lmode, m_lrgb, h, v),
                     (h < HA && v < VA),
                     !(h >= HA + HF && h < HA + HF + HS),
                     !(v >= VA + VF && v < VA + VF + VS),
                     (h == 0 && v == 0),
                     m_fcnt};
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ({red, green, blue, de, hsync, vsync, frame_start, frame_cnt} !== m_exp) begin
                n_err++;
                $display("FAIL model_cmp t=%0t: got rgb=%h de=%b hs=%b vs=%b fs=%b fc=%0d, expected rgb=%h de=%b hs=%b vs=%b fs=%b fc=%0d",
                         $time, {red, green, blue}, de, hsync, vsync, frame_start, frame_cnt,
                         m_exp[43:20], m_exp[19], m_exp[18], m_exp[17], m_exp[16], m_exp[15:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        k = k + 1;
    endtask

    task automatic adv(input int target);
        while (k < target) begin
            if (rnd_rgb)  solid_rgb = $urandom;
            if (rnd_mode) mode = 2'($urandom_range(0, 3));
            tick();
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_rgb"}, {8'h0, red, green, blue}, 32'h0);
        chk({name, "_ctl"}, {28'h0, de, hsync, vsync, frame_start}, 32'h6);
        chk({name, "_fcnt"}, {16'h0, frame_cnt}, 32'h0);
    endtask

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; solid_rgb = 24'h0; k = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk_reset_vals("reset");

        en = 1'b1;
        k  = -2;
        tick();
        chk("arm_idle", {31'h0, de}, 32'h0);
        tick();
        chk("first_fs", {30'h0, de, frame_start}, 32'h3);
        chk("first_rgb", {8'h0, red, green, blue}, 32'h0);
        rnd_rgb = 1;
        adv(100);     chk("bar1_blue", {8'h0, red, green, blue}, 32'h0000FF);
        adv(639);     chk("bar7_white", {8'h0, red, green, blue}, 32'hFFFFFF);
        adv(640);     chk("de_fall", {31'h0, de}, 32'h0);
        adv(655);     chk("hs_pre", {31'h0, hsync}, 32'h1);
        adv(656);     chk("hs_low", {31'h0, hsync}, 32'h0);
        adv(751);     chk("hs_last", {31'h0, hsync}, 32'h0);
        adv(752);     chk("hs_rise", {31'h0, hsync}, 32'h1);
        adv(800);     chk("line2", {30'h0, de, frame_start}, 32'h2);
        rnd_mode = 1;
        adv(10 * HT);
        rnd_mode = 0;
        mode = 2'd2;
        adv((VA + VF) * HT - 1);      chk("vs_pre", {31'h0, vsync}, 32'h1);
        adv((VA + VF) * HT);          chk("vs_low", {31'h0, vsync}, 32'h0);
        adv((VA + VF + VS) * HT - 1); chk("vs_last", {31'h0, vsync}, 32'h0);
        adv((VA + VF + VS) * HT);     chk("vs_rise", {31'h0, vsync}, 32'h1);
        adv(F - 2);   chk("fcnt_pre", {16'h0, frame_cnt}, 32'h0);
        adv(F);       chk("fs2", {31'h0, frame_start}, 32'h1);
        chk("fcnt1", {16'h0, frame_cnt}, 32'h1);
        adv(F + 32);  chk("chk_32_0", {8'h0, red, green, blue}, 32'hFFFFFF);
        mode = 2'd1;
        adv(F + 32 * HT + 32); chk("chk_32_32", {8'h0, red, green, blue}, 32'h000000);
        adv(2 * F + 400);      chk("ramp_400", {8'h0, red, green, blue}, 32'h646464);
        adv(2 * F + 5 * HT + 300);

        en = 1'b0;
        rnd_rgb = 0;
        tick();
        chk("dis_ctl", {24'h0, red | green | blue, de, hsync, vsync, frame_start}, 32'h6);
        chk("dis_fcnt", {16'h0, frame_cnt}, 32'h2);
        mode = 2'd3;
        solid_rgb = 24'h123456;
        repeat (5) tick();
        en = 1'b1;
        k  = -2;
        tick();       chk("reen_arm", {31'h0, frame_start}, 32'h0);
        tick();       chk("reen_fs", {31'h0, frame_start}, 32'h1);
        chk("solid_00", {8'h0, red, green, blue}, 32'h123456);
        adv(639);     chk("solid_639", {8'h0, red, green, blue}, 32'h123456);
        adv(700);     chk("solid_blank", {8'h0, red, green, blue}, 32'h0);
        rnd_rgb = 1;
        adv(HT + 400);
        chk("solid_latched", {8'h0, red, green, blue}, 32'h123456);

        #1 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        rnd_rgb = 0;
        tick();       chk("post_rst_arm", {31'h0, de}, 32'h0);
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
